// File: rtl/hhmm_display_mux.sv
// hhmm_display_mux: drives a 4-digit common-anode 7-segment panel from a BCD HH:MM bus.
// Time-multiplexes the digits with a blank guard cycle at the start of each slot.
// Takes one time snapshot per scan frame, so a frame never mixes two times.
// Adds optional blanking of a leading zero in tens-of-hours and a blinking colon.
// All outputs are registered. There is no combinational path from any input to any output.
module hhmm_display_mux #(
  parameter int SCAN_DIV     = 4,
  parameter int COLON_FRAMES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [3:0][3:0] d,
  input  logic            blank_lz,
  input  logic            colon_en,
  output logic [3:0]      an,
  output logic [6:0]      seg,
  output logic            dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (COLON_FRAMES > 1) ? $clog2(COLON_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FC_MAX  = FW'(COLON_FRAMES - 1);

  // Active-low segment pattern {g,f,e,d,c,b,a}; any non-BCD code shows a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  logic [CW-1:0]    cnt_r;
  logic [1:0]       idx_r;
  logic [3:0][3:0]  d_snap_r;
  logic [FW-1:0]    fc_r;
  logic             phase_r;

  logic             tick_s;
  logic             frame_end_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic [1:0]       idx_nxt_s;
  logic [FW-1:0]    fc_nxt_s;
  logic             phase_nxt_s;
  logic             slot_active_s;
  logic             blanked_s;
  logic [3:0]       an_nxt_s;
  logic [6:0]       seg_nxt_s;
  logic             dp_nxt_s;

  // Scan counters, frame-end strobe and colon phase next-state.
  always_comb begin
    tick_s      = (cnt_r == CNT_MAX);
    frame_end_s = tick_s && (idx_r == 2'd3);
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    fc_nxt_s    = fc_r;
    phase_nxt_s = phase_r;
    if (tick_s) begin
      cnt_nxt_s = {CW{1'b0}};
      idx_nxt_s = idx_r + 2'd1;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
    if (frame_end_s) begin
      if (fc_r == FC_MAX) begin
        fc_nxt_s    = {FW{1'b0}};
        phase_nxt_s = ~phase_r;
      end else begin
        fc_nxt_s = fc_r + FW'(1);
      end
    end else begin
      fc_nxt_s = fc_r;
    end
  end

  // Next panel drive. The first cycle of every slot keeps all anodes off.
  always_comb begin
    slot_active_s = (cnt_r != {CW{1'b0}});
    blanked_s     = (idx_r == 2'd3) && blank_lz && (d_snap_r[3] == 4'd0);
    an_nxt_s      = 4'b1111;
    if (slot_active_s && !blanked_s) begin
      an_nxt_s[idx_r] = 1'b0;
    end else begin
      an_nxt_s = 4'b1111;
    end
    seg_nxt_s = bcd_to_seg(d_snap_r[idx_r]);
    dp_nxt_s  = ~(slot_active_s && (idx_r == 2'd2) && colon_en && phase_r);
  end

  // Scan state, snapshot and colon phase registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r    <= {CW{1'b0}};
      idx_r    <= 2'd0;
      d_snap_r <= 16'h0000;
      fc_r     <= {FW{1'b0}};
      phase_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      fc_r    <= fc_nxt_s;
      phase_r <= phase_nxt_s;
      if (frame_end_s) begin
        d_snap_r <= d;
      end
    end
  end

  // Output registers, one clock behind the state that selects them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt_s;
      seg <= seg_nxt_s;
      dp  <= dp_nxt_s;
    end
  end

endmodule

// File: tb/tb_hhmm_display_mux.sv
// Directed bench for hhmm_display_mux with SCAN_DIV=4 and COLON_FRAMES=2.
// After output edge k (counting from reset release), the outputs reflect cnt=(k-1)%4,
// idx=((k-1)/4)%4 and frame (k-1)/16. A lit slot s in frame f is sampled at edge 16f+4s+3.
module tb_hhmm_display_mux;

  logic            clk;
  logic            rstn;
  logic [3:0][3:0] d;
  logic            blank_lz;
  logic            colon_en;
  logic [3:0]      an;
  logic [6:0]      seg;
  logic            dp;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cur       = 0;

  hhmm_display_mux #(.SCAN_DIV(4), .COLON_FRAMES(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .d        (d),
    .blank_lz (blank_lz),
    .colon_en (colon_en),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dv;
    logic        bl;
    logic        ce;
    int          slot;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance to just after output edge 'target' counted from reset release.
  task automatic goto(input int target);
    while (cur < target) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    cur = 0;
  endtask

  initial begin
    int lo [4];
    int blank_cycles;

    d = 16'h0000; blank_lz = 1'b0; colon_en = 1'b0;
    do_reset();

    vecs[0]  = '{16'h1234, 1'b0, 1'b0, 0, 4'b1110, 7'h19, 1'b1};
    vecs[1]  = '{16'h1234, 1'b0, 1'b0, 1, 4'b1101, 7'h30, 1'b1};
    vecs[2]  = '{16'h1234, 1'b0, 1'b0, 2, 4'b1011, 7'h24, 1'b1};
    vecs[3]  = '{16'h1234, 1'b0, 1'b0, 3, 4'b0111, 7'h79, 1'b1};
    vecs[4]  = '{16'h0905, 1'b1, 1'b0, 3, 4'b1111, 7'h40, 1'b1};
    vecs[5]  = '{16'h0905, 1'b0, 1'b0, 3, 4'b0111, 7'h40, 1'b1};
    vecs[6]  = '{16'h0905, 1'b1, 1'b0, 2, 4'b1011, 7'h10, 1'b1};
    vecs[7]  = '{16'h000C, 1'b0, 1'b0, 0, 4'b1110, 7'h3F, 1'b1};
    vecs[8]  = '{16'h5678, 1'b0, 1'b0, 0, 4'b1110, 7'h00, 1'b1};
    vecs[9]  = '{16'h5678, 1'b0, 1'b0, 1, 4'b1101, 7'h78, 1'b1};
    vecs[10] = '{16'h5678, 1'b0, 1'b0, 2, 4'b1011, 7'h02, 1'b1};
    vecs[11] = '{16'h5678, 1'b0, 1'b0, 3, 4'b0111, 7'h12, 1'b1};
    vecs[12] = '{16'h1234, 1'b0, 1'b1, 2, 4'b1011, 7'h24, 1'b1};
    vecs[13] = '{16'h1F34, 1'b1, 1'b0, 2, 4'b1011, 7'h3F, 1'b1};
    vecs[14] = '{16'h1234, 1'b1, 1'b0, 3, 4'b0111, 7'h79, 1'b1};

    // Mid-scan reset: outputs go to idle immediately, without waiting for a clock.
    d = 16'h1234;
    goto(7);
    rstn = 1'b0;
    #1;
    check("rst_an", {12'h0, an}, {12'h0, 4'b1111});
    check("rst_seg", {9'h0, seg}, {9'h0, 7'h7F});
    check("rst_dp", {15'h0, dp}, {15'h0, 1'b1});
    #1;
    rstn = 1'b1;
    cur = 0;

    // Frame 0 after release: each digit lit 3 clocks, 4 guard cycles.
    for (int i = 0; i < 4; i++) lo[i] = 0;
    blank_cycles = 0;
    for (int e = 1; e <= 16; e++) begin
      goto(e);
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) lo[i]++;
      if (an == 4'b1111) blank_cycles++;
    end
    for (int i = 0; i < 4; i++) check($sformatf("lit_cnt%0d", i), 16'(lo[i]), 16'd3);
    check("guard_cnt", 16'(blank_cycles), 16'd4);
    // Guard cycle still carries the decoded digit on seg.
    goto(25);
    check("guard_an", {12'h0, an}, {12'h0, 4'b1111});
    check("guard_seg", {9'h0, seg}, {9'h0, 7'h24});

    // Table-driven digit checks, sampled in frame 1 after the first snapshot.
    for (int v = 0; v < 15; v++) begin
      do_reset();
      d = vecs[v].dv; blank_lz = vecs[v].bl; colon_en = vecs[v].ce;
      goto(16 + 4 * vecs[v].slot + 3);
      check($sformatf("v%0d_an", v), {12'h0, an}, {12'h0, vecs[v].an_e});
      check($sformatf("v%0d_seg", v), {9'h0, seg}, {9'h0, vecs[v].seg_e});
      check($sformatf("v%0d_dp", v), {15'h0, dp}, {15'h0, vecs[v].dp_e});
    end

    // Before the first snapshot, the display shows zeros regardless of d.
    do_reset();
    d = 16'h9876; blank_lz = 1'b0; colon_en = 1'b0;
    goto(3);
    check("presnap_seg", {9'h0, seg}, {9'h0, 7'h40});

    // Tearing: d changes mid-frame; the rest of the frame keeps the old time.
    do_reset();
    d = 16'h1259; blank_lz = 1'b0; colon_en = 1'b0;
    goto(22);
    d = 16'h1300;
    goto(23); check("tear_f1s1", {9'h0, seg}, {9'h0, 7'h12});
    goto(27); check("tear_f1s2", {9'h0, seg}, {9'h0, 7'h24});
    goto(31); check("tear_f1s3", {9'h0, seg}, {9'h0, 7'h79});
    goto(35); check("tear_f2s0", {9'h0, seg}, {9'h0, 7'h40});
    goto(39); check("tear_f2s1", {9'h0, seg}, {9'h0, 7'h40});
    goto(43); check("tear_f2s2", {9'h0, seg}, {9'h0, 7'h30});

    // Colon: two frames off, two frames on, repeating; the colon appears only on digit 2.
    do_reset();
    d = 16'h1234; blank_lz = 1'b0; colon_en = 1'b1;
    goto(11);  check("colon_f0", {15'h0, dp}, 16'd1);
    goto(27);  check("colon_f1", {15'h0, dp}, 16'd1);
    goto(39);  check("colon_f2s1", {15'h0, dp}, 16'd1);
    goto(41);  check("colon_f2g", {15'h0, dp}, 16'd1);
    goto(43);  check("colon_f2", {15'h0, dp}, 16'd0);
    goto(59);  check("colon_f3", {15'h0, dp}, 16'd0);
    goto(75);  check("colon_f4", {15'h0, dp}, 16'd1);
    goto(91);  check("colon_f5", {15'h0, dp}, 16'd1);
    goto(107); check("colon_f6", {15'h0, dp}, 16'd0);
    colon_en = 1'b0;
    goto(123); check("colon_off", {15'h0, dp}, 16'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
